// File: rtl/bitty_issue_queue.sv
// Issue sequencer for bitty_core: buffers 16-bit instructions in a small FIFO and
// hands them to the core one at a time, retiring on core_done or a watchdog timeout.
module bitty_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    output logic        core_run,
    output logic [15:0] core_instruction,
    input  logic        core_done,
    output logic        busy,
    output logic [15:0] issued_count,
    output logic        timeout_err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, RETIRE} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [7:0]     wdog_q, wdog_d;
    logic           core_run_q, core_run_d;
    logic [15:0]    core_instr_q, core_instr_d;
    logic [15:0]    issued_count_q, issued_count_d;
    logic           timeout_err_q, timeout_err_d;
    logic [15:0]    mem_q [DEPTH];

    logic push;
    logic pop;

    assign in_ready = !reset && (count_q < CW'(DEPTH));
    // flush drops any push presented on the same edge
    assign push     = in_valid && in_ready && !flush;
    assign pop      = !flush && (state_q == IDLE) && (count_q != '0);

    always_comb begin
        state_d        = state_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        wdog_d         = wdog_q;
        core_run_d     = core_run_q;
        core_instr_d   = core_instr_q;
        issued_count_d = issued_count_q;
        timeout_err_d  = timeout_err_q;

        if (flush) begin
            state_d       = IDLE;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            count_d       = '0;
            core_run_d    = 1'b0;
            timeout_err_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            case (state_q)
                IDLE: begin
                    if (pop) begin
                        core_instr_d = mem_q[rd_ptr_q];
                        state_d      = LOAD;
                    end
                end
                LOAD: begin
                    wdog_d     = '0;
                    core_run_d = 1'b1;
                    state_d    = EXEC;
                end
                EXEC: begin
                    // done takes priority over a simultaneous watchdog expiry
                    if (core_done) begin
                        issued_count_d = issued_count_q + 1'b1;
                        core_run_d     = 1'b0;
                        state_d        = RETIRE;
                    end else if (wdog_q == 8'(TIMEOUT)) begin
                        timeout_err_d = 1'b1;
                        core_run_d    = 1'b0;
                        state_d       = RETIRE;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
                RETIRE: begin
                    core_run_d = 1'b0;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            wdog_q         <= '0;
            core_run_q     <= 1'b0;
            core_instr_q   <= 16'h0000;
            issued_count_q <= 16'h0000;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            wdog_q         <= wdog_d;
            core_run_q     <= core_run_d;
            core_instr_q   <= core_instr_d;
            issued_count_q <= issued_count_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_instr;
        end
    end

    assign core_run         = core_run_q;
    assign core_instruction = core_instr_q;
    assign issued_count     = issued_count_q;
    assign timeout_err      = timeout_err_q;
    assign busy             = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_bitty_issue_queue.sv
// Directed bench for bitty_issue_queue: scoreboard of expected issue order plus
// immediate-assertion checks of handshake, timing, timeout, flush and reset behaviour.
module tb_bitty_issue_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        core_run;
    logic [15:0] core_instruction;
    logic        core_done;
    logic        busy;
    logic [15:0] issued_count;
    logic        timeout_err;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q [$];
    logic [15:0] exp_issued = 16'h0000;

    bitty_issue_queue #(.DEPTH(4), .TIMEOUT(15)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_instr         (in_instr),
        .in_ready         (in_ready),
        .flush            (flush),
        .core_run         (core_run),
        .core_instruction (core_instruction),
        .core_done        (core_done),
        .busy             (busy),
        .issued_count     (issued_count),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w, input bit expect_issue);
        in_valid = 1'b1;
        in_instr = w;
        if (expect_issue) exp_q.push_back(w);
        tick();
        in_valid = 1'b0;
    endtask

    // wait (bounded) for core_run to be high, then compare against the scoreboard head
    task automatic wait_run();
        int n = 0;
        logic [15:0] e;
        while (core_run !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("run_rise", {31'b0, core_run}, 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("issue_instr", {16'b0, core_instruction}, {16'b0, e});
        end else begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", core_instruction);
        end
    endtask

    // core_run must stay high for exactly cyc cycles, then done retires it
    task automatic issue_one(input int cyc);
        wait_run();
        for (int i = 1; i < cyc; i++) begin
            tick();
            chk("run_hold", {31'b0, core_run}, 32'd1);
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("run_drop", {31'b0, core_run}, 32'd0);
        exp_issued = exp_issued + 16'd1;
        chk("issued_count", {16'b0, issued_count}, {16'b0, exp_issued});
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 16'h0;
        flush     = 1'b0;
        core_done = 1'b0;
        repeat (2) tick();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_run", {31'b0, core_run}, 32'd0);
        chk("rst_instr", {16'b0, core_instruction}, 32'h0);
        chk("rst_issued", {16'b0, issued_count}, 32'h0);
        chk("rst_terr", {31'b0, timeout_err}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // single issue: instruction visible from E1, run from E2 for 3 cycles
        push_word(16'h2448, 1'b1);
        chk("single_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("single_e1_instr", {16'b0, core_instruction}, 32'h2448);
        chk("single_e1_run", {31'b0, core_run}, 32'd0);
        issue_one(3);
        tick();
        chk("single_idle_busy", {31'b0, busy}, 32'd0);
        chk("single_hold_instr", {16'b0, core_instruction}, 32'h2448);

        // fill and order with the core stalled
        for (int i = 0; i < 5; i++) begin
            chk("fill_ready", {31'b0, in_ready}, 32'd1);
            push_word(16'hA000 + 16'(i), 1'b1);
        end
        chk("fill_full", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 5; i++) issue_one(2);

        // timeout: 16 cycles of run, sticky error, no count
        repeat (2) tick();
        push_word(16'h7E57, 1'b1);
        wait_run();
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (core_run !== 1'b1) break;
            n++;
        end
        chk("timeout_len", n, 32'd16);
        chk("timeout_err", {31'b0, timeout_err}, 32'd1);
        chk("timeout_issued", {16'b0, issued_count}, {16'b0, exp_issued});
        repeat (3) tick();
        chk("timeout_sticky", {31'b0, timeout_err}, 32'd1);
        push_word(16'h1234, 1'b1);
        issue_one(2);
        chk("timeout_sticky2", {31'b0, timeout_err}, 32'd1);

        // core_done in IDLE and in LOAD is ignored
        repeat (2) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("done_idle_ignored", {16'b0, issued_count}, {16'b0, exp_issued});
        push_word(16'h0BAD, 1'b1);
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("done_load_ignored", {16'b0, issued_count}, {16'b0, exp_issued});
        issue_one(3);

        // flush mid-EXEC with a same-cycle push
        repeat (2) tick();
        push_word(16'hF001, 1'b1);
        push_word(16'hF002, 1'b0);
        push_word(16'hF003, 1'b0);
        wait_run();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 16'hF004;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_run", {31'b0, core_run}, 32'd0);
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_terr", {31'b0, timeout_err}, 32'd0);
        chk("flush_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_issued", {16'b0, issued_count}, {16'b0, exp_issued});
        repeat (4) tick();
        chk("flush_no_issue", {30'b0, core_run, busy}, 32'd0);

        // reset mid-EXEC with two words queued
        push_word(16'hC001, 1'b1);
        push_word(16'hC002, 1'b0);
        push_word(16'hC003, 1'b0);
        wait_run();
        reset = 1'b1;
        tick();
        exp_issued = 16'h0000;
        chk("mid_rst_run", {31'b0, core_run}, 32'd0);
        chk("mid_rst_instr", {16'b0, core_instruction}, 32'h0);
        chk("mid_rst_issued", {16'b0, issued_count}, 32'h0);
        chk("mid_rst_terr", {31'b0, timeout_err}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_mid_rst_ready", {31'b0, in_ready}, 32'd1);
        repeat (4) tick();
        chk("post_mid_rst_idle", {30'b0, core_run, busy}, 32'd0);

        // issued_count wrap from 16'hFFFF
        force dut.issued_count_q = 16'hFFFF;
        tick();
        release dut.issued_count_q;
        #1;
        exp_issued = 16'hFFFF;
        chk("wrap_preload", {16'b0, issued_count}, 32'hFFFF);
        push_word(16'h5A5A, 1'b1);
        issue_one(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
